// File: rtl/data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_ctrl
// Description : Data-side memory for the MIPS core: word RAM plus an I/O page
//               with LEDs, synchronized switches, timer/compare and UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_ctrl #(
    parameter int          RAM_AW       = 10,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] MMIO_PAGE    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        uart_tx
);

    localparam int                 c_CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_RELOAD = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // Word offsets within the I/O page (addr[15:2])
    localparam logic [13:0] c_OFF_LED    = 14'd0;
    localparam logic [13:0] c_OFF_SW     = 14'd1;
    localparam logic [13:0] c_OFF_TIMER  = 14'd2;
    localparam logic [13:0] c_OFF_CMP    = 14'd3;
    localparam logic [13:0] c_OFF_UART   = 14'd4;
    localparam logic [13:0] c_OFF_STATUS = 14'd5;

    logic [31:0]        r_mem [0:(2**RAM_AW)-1];
    logic [15:0]        r_led;
    logic [15:0]        r_swMeta;
    logic [15:0]        r_swSync;
    logic [31:0]        r_timer;
    logic [31:0]        r_cmp;
    logic               r_match;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_clkCnt;
    logic [2:0]         r_bitIdx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic              w_mmioSel;
    logic [13:0]       w_mmioOff;
    logic [RAM_AW-1:0] w_ramIdx;
    logic              w_mmioWr;
    logic              w_wrLed;
    logic              w_wrTimer;
    logic              w_wrCmp;
    logic              w_wrUart;
    logic              w_busy;
    logic              w_unused;

    assign w_mmioSel = (addr[31:16] == MMIO_PAGE);
    assign w_mmioOff = addr[15:2];
    assign w_ramIdx  = addr[RAM_AW+1:2];
    assign w_mmioWr  = memwrite && w_mmioSel;
    assign w_wrLed   = w_mmioWr && (w_mmioOff == c_OFF_LED);
    assign w_wrTimer = w_mmioWr && (w_mmioOff == c_OFF_TIMER);
    assign w_wrCmp   = w_mmioWr && (w_mmioOff == c_OFF_CMP);
    assign w_wrUart  = w_mmioWr && (w_mmioOff == c_OFF_UART);
    assign w_busy    = (r_state != c_IDLE);
    assign w_unused  = &{1'b0, addr[1:0]};

    // RAM contents survive reset; async read returns pre-write data
    always_ff @(posedge clk) begin
        if (memwrite && !w_mmioSel) begin
            r_mem[w_ramIdx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led    <= '0;
            r_swMeta <= '0;
            r_swSync <= '0;
            r_timer  <= '0;
            r_cmp    <= 32'hFFFF_FFFF;
            r_match  <= 1'b0;
        end else begin
            r_swMeta <= sw;
            r_swSync <= r_swMeta;
            if (w_wrLed) begin
                r_led <= wdata[15:0];
            end
            r_timer <= w_wrTimer ? wdata : r_timer + 32'd1;
            if (w_wrCmp) begin
                r_cmp   <= wdata;
                r_match <= 1'b0;
            end else if (r_timer == r_cmp) begin
                r_match <= 1'b1;
            end
        end
    end

    // UART transmitter; r_tx is registered alongside the state so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_clkCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_wrUart) begin
                        r_shift  <= wdata[7:0];
                        r_clkCnt <= c_CNT_RELOAD;
                        r_tx     <= 1'b0;
                        r_state  <= c_START;
                    end
                end
                c_START: begin
                    if (r_clkCnt == '0) begin
                        r_clkCnt <= c_CNT_RELOAD;
                        r_bitIdx <= '0;
                        r_tx     <= r_shift[0];
                        r_state  <= c_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt - 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_clkCnt == '0) begin
                        r_clkCnt <= c_CNT_RELOAD;
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt - 1'b1;
                    end
                end
                c_STOP: begin
                    if (r_clkCnt == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_clkCnt <= r_clkCnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (w_mmioSel) begin
            case (w_mmioOff)
                c_OFF_LED:    rdata = {16'b0, r_led};
                c_OFF_SW:     rdata = {16'b0, r_swSync};
                c_OFF_TIMER:  rdata = r_timer;
                c_OFF_CMP:    rdata = r_cmp;
                c_OFF_UART:   rdata = {31'b0, w_busy};
                c_OFF_STATUS: rdata = {31'b0, r_match};
                default:      rdata = '0;
            endcase
        end else begin
            rdata = r_mem[w_ramIdx];
        end
    end

    assign led     = r_led;
    assign uart_tx = r_tx;

endmodule
`default_nettype wire
